// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_port_arbiter
//   Shares the single-port data memory between the MEM stage and the debug
//   unit. Defining DMEM_ARB_BURST_EN enables multi-word debug bursts.
//   Revision: 1.0
// ============================================================================
module dmem_port_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pipe_re,
   input  logic              pipe_we,
   input  logic [ADDR_W-1:0] pipe_addr,
   input  logic [DATA_W-1:0] pipe_wdata,
   output logic [DATA_W-1:0] pipe_rdata,
   output logic              pipe_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   input  logic [7:0]        dbg_len,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   localparam int ST_W  = $clog2(STARVE_MAX + 1);
   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DBG_ACC  = 2'd1,
      S_DBG_WAIT = 2'd2,
      S_DBG_ACK  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ST_W-1:0]   starve_q, starve_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic              dbg_ack_q, dbg_ack_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
   logic              pipe_busy;
   logic              grant;
   logic              next_word;

`ifdef DMEM_ARB_BURST_EN
   logic [7:0]        len_q, len_d;
   logic [7:0]        word_q, word_d;

   assign next_word = dbg_req & (word_q != len_q);
`else
   logic              unused_dbg_len;

   assign unused_dbg_len = ^dbg_len;
   assign next_word      = 1'b0;
`endif

   assign pipe_busy = pipe_re | pipe_we;
   // A waiting request wins once it has starved for STARVE_MAX busy cycles.
   assign grant     = dbg_req & (~pipe_busy | (starve_q == ST_W'(STARVE_MAX)));

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      lat_d       = lat_q;
      addr_d      = addr_q;
      we_d        = we_q;
      dbg_ack_d   = 1'b0;
      dbg_rdata_d = dbg_rdata_q;
`ifdef DMEM_ARB_BURST_EN
      len_d       = len_q;
      word_d      = word_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (grant) begin
               state_d  = S_DBG_ACC;
               starve_d = '0;
               addr_d   = dbg_addr;
               we_d     = dbg_we;
`ifdef DMEM_ARB_BURST_EN
               len_d    = dbg_len;
               word_d   = 8'd0;
`endif
            end else if (dbg_req) begin
               starve_d = starve_q + ST_W'(1);
            end else begin
               starve_d = '0;
            end
         end
         S_DBG_ACC: begin
            if (we_q) begin
               state_d   = S_DBG_ACK;
               dbg_ack_d = 1'b1;
            end else begin
               state_d = S_DBG_WAIT;
               lat_d   = LAT_W'(MEM_LAT - 1);
            end
         end
         S_DBG_WAIT: begin
            if (lat_q == '0) begin
               state_d     = S_DBG_ACK;
               dbg_ack_d   = 1'b1;
               dbg_rdata_d = mem_dout;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         S_DBG_ACK: begin
            if (next_word) begin
               state_d = S_DBG_ACC;
               addr_d  = addr_q + ADDR_W'(1);
`ifdef DMEM_ARB_BURST_EN
               word_d  = word_q + 8'd1;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         starve_q    <= '0;
         lat_q       <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         dbg_ack_q   <= 1'b0;
         dbg_rdata_q <= '0;
`ifdef DMEM_ARB_BURST_EN
         len_q       <= 8'd0;
         word_q      <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         lat_q       <= lat_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         dbg_ack_q   <= dbg_ack_d;
         dbg_rdata_q <= dbg_rdata_d;
`ifdef DMEM_ARB_BURST_EN
         len_q       <= len_d;
         word_q      <= word_d;
`endif
      end
   end

   // Only DBG_ACC may write on behalf of debug; the pipeline never writes outside IDLE.
   always_comb begin
      if (state_q == S_IDLE) begin
         mem_we   = pipe_we;
         mem_addr = pipe_addr;
         mem_din  = pipe_wdata;
      end else begin
         mem_we   = (state_q == S_DBG_ACC) & we_q;
         mem_addr = addr_q;
         mem_din  = dbg_wdata;
      end
   end

   assign pipe_stall = (state_q != S_IDLE) & pipe_busy;
   assign pipe_rdata = mem_dout;
   assign dbg_ack    = dbg_ack_q;
   assign dbg_rdata  = dbg_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_port_arbiter
//   Directed and randomized checks of dmem_port_arbiter against a cycle-count
//   model of its arbitration and latency rules. Revision: 1.0
// ============================================================================
module tb_dmem_port_arbiter;

   localparam int AW         = 10;
   localparam int DW         = 32;
   localparam int MEM_LAT    = 1;
   localparam int STARVE_MAX = 15;
`ifdef DMEM_ARB_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          pipe_re, pipe_we;
   logic [AW-1:0] pipe_addr;
   logic [DW-1:0] pipe_wdata, pipe_rdata;
   logic          pipe_stall;
   logic          dbg_req, dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic [7:0]    dbg_len;
   logic          dbg_ack;
   logic [DW-1:0] dbg_rdata;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din, mem_dout;

   logic [DW-1:0] ram   [1024];
   logic [DW-1:0] model [1024];
   bit            model_ok [1024];
   int            tests = 0;
   int            fails = 0;

   dmem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clock(clk), .reset(rst),
      .pipe_re(pipe_re), .pipe_we(pipe_we), .pipe_addr(pipe_addr),
      .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_len(dbg_len), .dbg_ack(dbg_ack),
      .dbg_rdata(dbg_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // Single-port synchronous RAM, one cycle read latency.
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pipe_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      pipe_re = ~we; pipe_we = we; pipe_addr = a; pipe_wdata = d; dbg_req = 1'b0;
      @(negedge clk);
      chk("pipe_stall_idle", 32'(pipe_stall), 32'd0);
      chk("pipe_mem_addr", 32'(mem_addr), 32'(a));
      chk("pipe_mem_we", 32'(mem_we), 32'(we));
      tick;
      if (we) begin
         model[a]    = d;
         model_ok[a] = 1'b1;
      end
      pipe_re = 1'b0; pipe_we = 1'b0;
      @(negedge clk);
      if (!we && model_ok[a]) chk("pipe_rdata", pipe_rdata, model[a]);
      tick;
   endtask

   // Request raised at t=0; pipe busy for the first busy_k cycles.
   task automatic dbg_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int busy_k, input logic [7:0] len, input bit drop_first);
      int g, per, nw, acks, dut_acks, w;
      bit own, exp_ack;
      logic [AW-1:0] wa;
      g   = (busy_k < STARVE_MAX) ? busy_k : STARVE_MAX;
      per = we ? 2 : MEM_LAT + 2;
      nw  = (BURST && !drop_first) ? int'(len) + 1 : 1;
      acks = 0; dut_acks = 0;
      dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_len = len;
      pipe_we = 1'b0;
      for (int t = 0; t < g + per * nw + 3; t++) begin
         pipe_re   = (t < busy_k);
         pipe_addr = AW'($urandom);
         @(negedge clk);
         own = (t > g) && (t <= g + per * nw);
         chk("dbg_stall", 32'(pipe_stall), 32'(own && pipe_re));
         if (own) begin
            w  = (t - g - 1) / per;
            wa = a + AW'(w);
            chk("dbg_mem_addr", 32'(mem_addr), 32'(wa));
         end else begin
            chk("idle_mem_addr", 32'(mem_addr), 32'(pipe_addr));
         end
         exp_ack = own && ((t - g) % per == 0);
         chk("dbg_ack", 32'(dbg_ack), 32'(exp_ack));
         if (dbg_ack) dut_acks++;
         if (exp_ack) begin
            acks++;
            w  = (t - g) / per - 1;
            wa = a + AW'(w);
            if (we) begin
               model[wa]    = wd + DW'(w);
               model_ok[wa] = 1'b1;
               dbg_wdata    = wd + DW'(w + 1);
            end else if (model_ok[wa]) begin
               chk("dbg_rdata", dbg_rdata, model[wa]);
            end
            if (acks == nw) dbg_req = 1'b0;
         end
         tick;
      end
      chk("dbg_ack_count", 32'(dut_acks), 32'(nw));
      dbg_req = 1'b0;
   endtask

   initial begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      rst = 1'b1;
      pipe_re = 1'b1; pipe_we = 1'b0; pipe_addr = 10'h055; pipe_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_len = '0;
      tick; tick;
      @(negedge clk);
      chk("rst_ack", 32'(dbg_ack), 32'd0);
      chk("rst_stall", 32'(pipe_stall), 32'd0);
      chk("rst_rdata", dbg_rdata, 32'd0);
      chk("rst_mux", 32'(mem_addr), 32'(10'h055));
      rst = 1'b0; pipe_re = 1'b0;
      tick;

      // Pipeline only
      pipe_op(1'b1, 10'h010, 32'hDEADBEEF);
      pipe_op(1'b0, 10'h010, '0);

      // Debug write then read on an idle pipe, top of address space
      dbg_op(1'b1, 10'h3FF, 32'h12345678, 0, 8'd0, 1'b0);
      dbg_op(1'b0, 10'h3FF, '0, 0, 8'd0, 1'b0);

      // Starvation: pipe continuously busy
      dbg_op(1'b0, 10'h3FF, '0, 40, 8'd0, 1'b0);
      dbg_op(1'b1, 10'h3FF, 32'h0BADF00D, 15, 8'd0, 1'b0);

      // Burst read across the address wrap
      pipe_op(1'b1, 10'h3FE, 32'hA0A0A0A0);
      pipe_op(1'b1, 10'h3FF, 32'hA1A1A1A1);
      pipe_op(1'b1, 10'h000, 32'hA2A2A2A2);
      pipe_op(1'b1, 10'h001, 32'hA3A3A3A3);
      dbg_op(1'b0, 10'h3FE, '0, 0, 8'd3, 1'b0);

      // Request dropped in the first ack cycle of a 4-word burst
      dbg_op(1'b0, 10'h3FE, '0, 2, 8'd3, 1'b1);

      // Asynchronous reset while waiting on read data
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h3FF; dbg_len = 8'd0; pipe_re = 1'b0;
      tick; tick;
      pipe_re = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk("arst_ack", 32'(dbg_ack), 32'd0);
      chk("arst_stall", 32'(pipe_stall), 32'd0);
      chk("arst_rdata", dbg_rdata, 32'd0);
      dbg_req = 1'b0;
      #1 rst = 1'b0;
      pipe_re = 1'b0; pipe_we = 1'b1; pipe_addr = 10'h020; pipe_wdata = 32'hCAFEF00D;
      #1;
      chk("arst_pipe_we", 32'(mem_we), 32'd1);
      chk("arst_pipe_addr", 32'(mem_addr), 32'(10'h020));
      chk("arst_pipe_din", mem_din, 32'hCAFEF00D);
      tick;
      model[10'h020] = 32'hCAFEF00D; model_ok[10'h020] = 1'b1;
      pipe_we = 1'b0;
      tick;
      pipe_op(1'b0, 10'h020, '0);

      // Randomized mix of pipeline and debug traffic
      for (int i = 0; i < 40; i++) begin
         ra = 10'h100 + AW'($urandom_range(0, 7));
         rd = $urandom;
         case ($urandom_range(0, 3))
            0: pipe_op(1'b1, ra, rd);
            1: pipe_op(1'b0, ra, '0);
            2: dbg_op(1'b1, ra, rd, int'($urandom_range(0, 20)),
                      8'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
            default: dbg_op(1'b0, ra, rd, int'($urandom_range(0, 20)),
                            8'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
